// File: rtl/uart_kbd_rx.sv
// UART keyboard receiver: deserialises frames, buffers bytes in a FIFO and presents LC-3 KBSR/KBDR.
// Define KBD_PARITY_EN for 8E1 frames with parity checking (kbsr[11]); otherwise frames are 8N1.
//
// state | meaning
// IDLE  | line idle, waiting for a synchronised low
// START | confirming the start bit at mid-bit
// DATA  | shifting in 8 data bits, LSB first
// PAR   | sampling the even-parity bit (KBD_PARITY_EN only)
// STOP  | sampling the stop bit; queue the byte or flag ferr
module uart_kbd_rx #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  input  logic        rd_kbdr,
  input  logic        wr_kbsr,
  input  logic [15:0] wr_data,
  output logic [15:0] kbsr,
  output logic [15:0] kbdr,
  output logic        int_req
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

`ifdef KBD_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic             rxd_meta, rxd_s;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       smp_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             push_req;
  logic [7:0]       push_byte;
  logic             ferr_set, perr_set, par_bad;
  logic             tick, sample;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty, full, do_push, do_pop, ovr_set;
  logic             ie, ovr, ferr, perr;

  assign tick    = (div_cnt == '0);
  assign sample  = (state != IDLE) && tick && (smp_cnt == 4'd0);
  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = rd_kbdr && !empty;
  assign do_push = push_req && (!full || do_pop);
  assign ovr_set = push_req && full && !do_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // smp_cnt is a down-counter: 8 ticks to the start-bit centre, then 16 per bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= DIV_LAST;
      smp_cnt   <= 4'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      push_req  <= 1'b0;
      push_byte <= 8'h00;
      ferr_set  <= 1'b0;
      perr_set  <= 1'b0;
      par_bad   <= 1'b0;
    end else begin
      push_req <= 1'b0;
      ferr_set <= 1'b0;
      perr_set <= 1'b0;
      if (state == IDLE || tick) div_cnt <= DIV_LAST;
      else                       div_cnt <= div_cnt - DIV_W'(1);
      if (state != IDLE && tick)
        smp_cnt <= (smp_cnt == 4'd0) ? 4'd15 : smp_cnt - 4'd1;
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state   <= START;
            smp_cnt <= 4'd7;
            par_bad <= 1'b0;
          end
        end
        START: begin
          if (sample) begin
            state   <= rxd_s ? IDLE : DATA;
            bit_cnt <= 3'd7;
          end
        end
        DATA: begin
          if (sample) begin
            shreg   <= {rxd_s, shreg[7:1]};
            bit_cnt <= bit_cnt - 3'd1;
`ifdef KBD_PARITY_EN
            if (bit_cnt == 3'd0) state <= PAR;
`else
            if (bit_cnt == 3'd0) state <= STOP;
`endif
          end
        end
`ifdef KBD_PARITY_EN
        PAR: begin
          if (sample) begin
            par_bad  <= ^{shreg, rxd_s};
            perr_set <= ^{shreg, rxd_s};
            state    <= STOP;
          end
        end
`endif
        STOP: begin
          if (sample) begin
            state <= IDLE;
            if (!rxd_s) begin
              ferr_set <= 1'b1;
            end else if (!par_bad) begin
              push_req  <= 1'b1;
              push_byte <= shreg;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_byte;
  end

  // Error sets are applied after the W1C clears so that a set in the same clk wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ie     <= 1'b0;
      ovr    <= 1'b0;
      ferr   <= 1'b0;
      perr   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_kbsr) begin
        ie <= wr_data[14];
        if (wr_data[13]) ovr  <= 1'b0;
        if (wr_data[12]) ferr <= 1'b0;
`ifdef KBD_PARITY_EN
        if (wr_data[11]) perr <= 1'b0;
`endif
      end
      if (ovr_set)  ovr  <= 1'b1;
      if (ferr_set) ferr <= 1'b1;
      if (perr_set) perr <= 1'b1;
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kbsr    <= 16'h0000;
      kbdr    <= 16'h0000;
      int_req <= 1'b0;
    end else begin
      kbsr    <= {!empty, ie, ovr, ferr, perr, 11'b0};
      kbdr    <= empty ? 16'h0000 : {8'h00, mem[rd_ptr]};
      int_req <= kbsr[14] & kbsr[15];
    end
  end

endmodule
